// File: rtl/rtc_bcd_clock.sv
// rtc_bcd_clock
//   BCD time-of-day clock (hh:mm:ss) advanced once per second from a prescaler
//   running in the clk_m domain. Features: time-set load handshake with range
//   validation, run/pause, 12/24-hour display mapping, and a day-rollover pulse.
//   The optional alarm comparator is compiled in when RTC_ALARM_EN is defined.
//   rst asserts asynchronously. The reset controller is expected to release it
//   synchronously to clk_m.
module rtc_bcd_clock #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int DIGIT_W = 8
) (
  input  logic                 clk_m,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 mode12,
  input  logic                 set_valid,
  input  logic [23:0]          set_time,
  output logic                 set_ack,
  output logic                 set_err,
  output logic                 sec_tick,
  output logic                 day_roll,
  output logic                 pm,
`ifdef RTC_ALARM_EN
  input  logic                 alarm_set,
  input  logic [23:0]          alarm_time,
  input  logic                 alarm_en,
  output logic                 alarm,
`endif
  output logic [6*DIGIT_W-1:0] timestruct
);

  localparam int PRESC_W = $clog2(CLK_HZ);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);

  // Field order matches set_time: {h_t, h_o, m_t, m_o, s_t, s_o}.
  typedef struct packed {
    logic [3:0] h_t;
    logic [3:0] h_o;
    logic [3:0] m_t;
    logic [3:0] m_o;
    logic [3:0] s_t;
    logic [3:0] s_o;
  } bcd_time_t;

  localparam bcd_time_t MIDNIGHT = 24'h000000;
  localparam bcd_time_t LAST_SEC = 24'h235959;

  // True when every digit is legal BCD and the value is a real 24-hour time.
  function automatic logic time_ok(input bcd_time_t t);
    return (t.h_t <= 4'd2) && (t.h_o <= 4'd9) &&
           (t.m_t <= 4'd5) && (t.m_o <= 4'd9) &&
           (t.s_t <= 4'd5) && (t.s_o <= 4'd9) &&
           !((t.h_t == 4'd2) && (t.h_o > 4'd3));
  endfunction

  // One-second BCD increment with ripple carry; 23:59:59 wraps to 00:00:00.
  function automatic bcd_time_t time_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.s_o != 4'd9) begin
      r.s_o = t.s_o + 4'd1;
    end else begin
      r.s_o = 4'd0;
      if (t.s_t != 4'd5) begin
        r.s_t = t.s_t + 4'd1;
      end else begin
        r.s_t = 4'd0;
        if (t.m_o != 4'd9) begin
          r.m_o = t.m_o + 4'd1;
        end else begin
          r.m_o = 4'd0;
          if (t.m_t != 4'd5) begin
            r.m_t = t.m_t + 4'd1;
          end else begin
            r.m_t = 4'd0;
            if ((t.h_t == 4'd2) && (t.h_o == 4'd3)) begin
              r.h_t = 4'd0;
              r.h_o = 4'd0;
            end else if (t.h_o == 4'd9) begin
              r.h_o = 4'd0;
              r.h_t = t.h_t + 4'd1;
            end else begin
              r.h_o = t.h_o + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  // Zero-extends a BCD nibble to a timestruct digit field.
  function automatic logic [DIGIT_W-1:0] pad(input logic [3:0] n);
    logic [DIGIT_W-1:0] v;
    v      = '0;
    v[3:0] = n;
    return v;
  endfunction

  logic [PRESC_W-1:0] presc;
  bcd_time_t          cur;
  bcd_time_t          time_next;
  bcd_time_t          set_bcd;
  logic               load_ok;
  logic               load_bad;
  logic               tick;
  logic               advance;

  logic [4:0]         hour_bin;
  logic [4:0]         disp_hour;
  logic [3:0]         disp_h_t;
  logic [3:0]         disp_h_o;

  assign set_bcd = bcd_time_t'(set_time);

  // Load validation, tick detection and next time value; a valid load wins over a tick.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    load_ok   = set_valid && time_ok(set_bcd);
    load_bad  = set_valid && !load_ok;
    tick      = run && (presc == PRESC_MAX);
    advance   = tick && !load_ok;
    time_next = cur;
    if (load_ok) begin
      time_next = set_bcd;
    end else if (advance) begin
      time_next = time_inc(cur);
    end
  end

  // Prescaler: counts 0..CLK_HZ-1 while running, restarts on an accepted load.
  always_ff @(posedge clk_m or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      presc <= '0;
    end else if (load_ok) begin
      presc <= '0;
    end else if (run) begin
      presc <= (presc == PRESC_MAX) ? '0 : presc + PRESC_W'(1);
    end
  end

  // Time registers.
  always_ff @(posedge clk_m or posedge rst) begin
    if (rst) begin
      cur <= MIDNIGHT;
    end else begin
      cur <= time_next;
    end
  end

  // Status pulses, registered on the same edge that updates the time.
  always_ff @(posedge clk_m or posedge rst) begin
    if (rst) begin
      set_ack  <= 1'b0;
      set_err  <= 1'b0;
      sec_tick <= 1'b0;
      day_roll <= 1'b0;
    end else begin
      set_ack  <= load_ok;
      set_err  <= load_bad;
      sec_tick <= advance;
      day_roll <= advance && (cur == LAST_SEC);
    end
  end

  // Display hour mapping: 24-hour passthrough or 12-hour (0->12, 13..23->1..11).
  always_comb begin
    hour_bin  = 5'(cur.h_t) * 5'd10 + 5'(cur.h_o);
    disp_hour = hour_bin;
    if (mode12) begin
      if (hour_bin == 5'd0) begin
        disp_hour = 5'd12;
      end else if (hour_bin > 5'd12) begin
        disp_hour = hour_bin - 5'd12;
      end
    end
    if (disp_hour >= 5'd20) begin
      disp_h_t = 4'd2;
      disp_h_o = 4'(disp_hour - 5'd20);
    end else if (disp_hour >= 5'd10) begin
      disp_h_t = 4'd1;
      disp_h_o = 4'(disp_hour - 5'd10);
    end else begin
      disp_h_t = 4'd0;
      disp_h_o = 4'(disp_hour);
    end
  end

  assign pm = (hour_bin >= 5'd12);

  // Packed from the most significant field down: s_o, s_t, m_o, m_t, h_o, h_t.
  assign timestruct = {pad(cur.s_o), pad(cur.s_t), pad(cur.m_o),
                       pad(cur.m_t), pad(disp_h_o), pad(disp_h_t)};

`ifdef RTC_ALARM_EN
  bcd_time_t alarm_reg;
  bcd_time_t alarm_bcd;

  assign alarm_bcd = bcd_time_t'(alarm_time);

  // Alarm register load and match pulse on any time update that lands on it.
  always_ff @(posedge clk_m or posedge rst) begin
    if (rst) begin
      alarm_reg <= MIDNIGHT;
      alarm     <= 1'b0;
    end else begin
      if (alarm_set && time_ok(alarm_bcd)) begin
        alarm_reg <= alarm_bcd;
      end
      alarm <= alarm_en && (load_ok || advance) && (time_next == alarm_reg);
    end
  end
`endif

endmodule
